// File: rtl/wb_syscon_pkg.sv
// Shared types and helpers for the Wishbone SYSCON reset sequencer.
//   seq_state_t : sequencer phases SYNC -> HOLD -> STAGGER -> RUN
//   cnt_width() : bits needed to hold a counter value 0..max_val (minimum 1)
package wb_syscon_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    STAGGER = 2'd2,
    RUN     = 2'd3
  } seq_state_t;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wb_rst_sync.sv
// Asynchronous-assert / synchronous-deassert reset synchroniser.
//   clk_i      : destination clock
//   rst_i      : raw asynchronous reset, active-high
//   rst_o      : synchronised reset (last stage), asserts immediately with rst_i
//   rst_next_o : value rst_o takes on the next clk_i edge; lets a consumer
//                act on the same edge the synchronised reset falls
module wb_rst_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic rst_o,
  output logic rst_next_o
);

  logic [STAGES-1:0] chain_q;

  // Zeros enter at stage 0 and ripple toward the output once rst_i drops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], 1'b0};
    end
  end

  assign rst_o      = chain_q[STAGES-1];
  assign rst_next_o = chain_q[STAGES-2];

endmodule

// File: rtl/wb_syscon_seq.sv
// Wishbone SYSCON reset sequencer.
// Holds all reset channels after the board reset (or a global synchronous
// reset request), then releases them one by one, STAGGER cycles apart.
// Individual released channels can be pulsed through sync_rst_o by a soft
// reset request.
//   clk_i          : module clock
//   async_rst_i    : board reset, asynchronous, active-high
//   sync_rst_i     : global synchronous reset request, level
//   soft_rst_req_i : per-channel soft reset request
//   async_rst_o    : per-channel reset, async assert / sync deassert
//   sync_rst_o     : per-channel synchronous reset (includes soft pulses)
//   rst_done_o     : every channel released, sequencer in RUN
module wb_syscon_seq
  import wb_syscon_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned STAGGER     = 2
) (
  input  logic                clk_i,
  input  logic                async_rst_i,
  input  logic                sync_rst_i,
  input  logic [CHANNELS-1:0] soft_rst_req_i,
  output logic [CHANNELS-1:0] async_rst_o,
  output logic [CHANNELS-1:0] sync_rst_o,
  output logic                rst_done_o
);

  // Sequence counter terminal value: the count at which the last channel frees.
  localparam int unsigned TERM   = HOLD_CYCLES + (CHANNELS - 1) * STAGGER;
  localparam int unsigned SEQ_W  = cnt_width(TERM);
  localparam int unsigned SOFT_W = cnt_width(HOLD_CYCLES);

  localparam logic [SEQ_W-1:0]  TERM_C     = SEQ_W'(TERM);
  localparam logic [SEQ_W-1:0]  HOLD_C     = SEQ_W'(HOLD_CYCLES);
  localparam logic [SOFT_W-1:0] SOFT_LEN_C = SOFT_W'(HOLD_CYCLES);

  logic sync_out;
  logic sync_next;

  wb_rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk_i      (clk_i),
    .rst_i      (async_rst_i),
    .rst_o      (sync_out),
    .rst_next_o (sync_next)
  );

  seq_state_t          state_q,   state_d;
  logic [SEQ_W-1:0]    seq_cnt_q, seq_cnt_d;
  logic [CHANNELS-1:0] ar_q,      ar_d;
  logic [CHANNELS-1:0] sr_q,      sr_d;
  logic                done_q,    done_d;
  logic [SOFT_W-1:0]   soft_cnt_q [CHANNELS];
  logic [SOFT_W-1:0]   soft_cnt_d [CHANNELS];

  // Sequencer next state. The counter is zero on entry to HOLD and counts
  // every edge afterwards; channel k frees when it reaches HOLD+k*STAGGER.
  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    if (sync_rst_i) begin
      state_d   = HOLD;
      seq_cnt_d = '0;
    end else begin
      case (state_q)
        SYNC: begin
          // Move on the very edge the synchroniser output falls.
          if (!sync_next || !sync_out) begin
            state_d   = HOLD;
            seq_cnt_d = '0;
          end
        end
        HOLD, wb_syscon_pkg::STAGGER: begin
          seq_cnt_d = (seq_cnt_q >= TERM_C) ? TERM_C : seq_cnt_q + SEQ_W'(1);
          if (seq_cnt_d >= TERM_C) begin
            state_d = RUN;
          end else if (seq_cnt_d >= HOLD_C) begin
            state_d = wb_syscon_pkg::STAGGER;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
        end
      endcase
    end
    done_d = (state_d == RUN);
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    localparam logic [SEQ_W-1:0] THR_C = SEQ_W'(HOLD_CYCLES + gi * STAGGER);

    // Counter is zero in SYNC and right after a global reset, and every
    // threshold is at least 1, so this alone covers all reset phases.
    assign ar_d[gi] = (seq_cnt_d < THR_C);

    // Soft pulse: loaded with the pulse length on a request for an already
    // released channel, then counts down; output stays high while nonzero.
    assign soft_cnt_d[gi] = sync_rst_i                              ? '0 :
                            (soft_rst_req_i[gi] && !ar_q[gi])       ? SOFT_LEN_C :
                            (soft_cnt_q[gi] != '0)                  ? soft_cnt_q[gi] - SOFT_W'(1) :
                                                                      '0;

    assign sr_d[gi] = ar_d[gi] || (soft_cnt_d[gi] != '0);

    always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
        soft_cnt_q[gi] <= '0;
      end else begin
        soft_cnt_q[gi] <= soft_cnt_d[gi];
      end
    end
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q   <= SYNC;
      seq_cnt_q <= '0;
      ar_q      <= '1;
      sr_q      <= '1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_cnt_q <= seq_cnt_d;
      ar_q      <= ar_d;
      sr_q      <= sr_d;
      done_q    <= done_d;
    end
  end

  assign async_rst_o = ar_q;
  assign sync_rst_o  = sr_q;
  assign rst_done_o  = done_q;

endmodule

// File: tb/tb_wb_syscon_seq.sv
// Bench for wb_syscon_seq: instance 0 uses default parameters, instance 1 uses
// CHANNELS=1, HOLD_CYCLES=1, STAGGER=0. The reference model keeps, per channel,
// the absolute edge number at which it is released and at which its soft
// pulse ends, derived from the release schedule formulas.
module tb_wb_syscon_seq;

  localparam int INF = 1 << 30;
  localparam int SS  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] arst = '0;
  logic [1:0] srst = '0;
  logic [3:0] req0 = '0;
  logic [0:0] req1 = '0;
  logic [3:0] ar0, sr0;
  logic       dn0;
  logic [0:0] ar1, sr1;
  logic       dn1;

  wb_syscon_seq #(.CHANNELS(4), .SYNC_STAGES(2), .HOLD_CYCLES(4), .STAGGER(2)) dut0 (
    .clk_i(clk), .async_rst_i(arst[0]), .sync_rst_i(srst[0]), .soft_rst_req_i(req0),
    .async_rst_o(ar0), .sync_rst_o(sr0), .rst_done_o(dn0)
  );

  wb_syscon_seq #(.CHANNELS(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .STAGGER(0)) dut1 (
    .clk_i(clk), .async_rst_i(arst[1]), .sync_rst_i(srst[1]), .soft_rst_req_i(req1),
    .async_rst_o(ar1), .sync_rst_o(sr1), .rst_done_o(dn1)
  );

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  int rel_e  [2][4];
  int soft_e [2][4];
  int base0, base1;
  logic [3:0] m_rq;

  function automatic int nch(input int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int hld(input int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int stg(input int i); return (i == 0) ? 2 : 0; endfunction

  // Reference model, advanced once per rising edge.
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    for (int i = 0; i < 2; i++) begin
      m_rq = (i == 0) ? req0 : {3'b000, req1};
      for (int k = 0; k < 4; k++) begin
        if (k < nch(i)) begin
          if (arst[i]) begin
            rel_e[i][k]  = INF;
            soft_e[i][k] = 0;
          end else if (srst[i]) begin
            rel_e[i][k]  = edge_n + hld(i) + k * stg(i);
            soft_e[i][k] = 0;
          end else if (m_rq[k] && (edge_n - 1 >= rel_e[i][k])) begin
            soft_e[i][k] = edge_n + hld(i);
          end
        end
      end
    end
  end

  task automatic m_async_assert(input int i);
    for (int k = 0; k < 4; k++) begin
      rel_e[i][k]  = INF;
      soft_e[i][k] = 0;
    end
  endtask

  // Called between edges: the next edge is E1.
  task automatic m_async_release(input int i);
    for (int k = 0; k < nch(i); k++) rel_e[i][k] = edge_n + SS + hld(i) + k * stg(i);
  endtask

  function automatic logic [3:0] exp_ar(input int i);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < nch(i); k++) r[k] = (edge_n < rel_e[i][k]);
    return r;
  endfunction

  function automatic logic [3:0] exp_sr(input int i);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < nch(i); k++) r[k] = (edge_n < rel_e[i][k]) || (edge_n < soft_e[i][k]);
    return r;
  endfunction

  function automatic logic exp_dn(input int i);
    return edge_n >= rel_e[i][nch(i) - 1];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    arst = 2'b11;
    m_async_assert(0);
    m_async_assert(1);
    #1;
    if ({ar0, sr0, dn0, ar1, sr1, dn1} !== {4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_async ar0=%b sr0=%b dn0=%b ar1=%b sr1=%b dn1=%b expected all resets high, done low",
               ar0, sr0, dn0, ar1, sr1, dn1);
    end
    checks++;
    repeat (3) begin
      cyc();
      if ({ar0, sr0, dn0} !== {exp_ar(0), exp_sr(0), exp_dn(0)}) begin
        errors++;
        $display("FAIL reset_hold edge=%0d ar=%b sr=%b done=%b expected ar=%b sr=%b done=%b",
                 edge_n, ar0, sr0, dn0, exp_ar(0), exp_sr(0), exp_dn(0));
      end
      checks++;
    end
    #2;
    arst[0] = 1'b0;
    m_async_release(0);
    base0 = edge_n;
  endtask

  task automatic test_sequence();
    int done_at;
    done_at = -1;
    for (int c = 0; c < 14; c++) begin
      cyc();
      if ({ar0, sr0, dn0} !== {exp_ar(0), exp_sr(0), exp_dn(0)}) begin
        errors++;
        $display("FAIL sequence edge=E%0d ar=%b sr=%b done=%b expected ar=%b sr=%b done=%b",
                 edge_n - base0, ar0, sr0, dn0, exp_ar(0), exp_sr(0), exp_dn(0));
      end
      checks++;
      if (edge_n - base0 == 6) begin
        if (ar0 !== 4'b1110) begin
          errors++;
          $display("FAIL sequence_e6 ar=%b expected 1110", ar0);
        end
        checks++;
      end
      if (dn0 === 1'b1 && done_at < 0) done_at = edge_n - base0;
    end
    if (done_at !== 12) begin
      errors++;
      $display("FAIL sequence_done_edge got E%0d expected E12", done_at);
    end
    checks++;
  endtask

  task automatic test_sync_rst();
    int n, es, done_at;
    repeat (5) begin
      cyc();
      if ({ar0, sr0, dn0} !== {exp_ar(0), exp_sr(0), exp_dn(0)}) begin
        errors++;
        $display("FAIL sync_pre edge=%0d ar=%b sr=%b done=%b expected ar=%b sr=%b done=%b",
                 edge_n, ar0, sr0, dn0, exp_ar(0), exp_sr(0), exp_dn(0));
      end
      checks++;
    end
    n = $urandom_range(1, 3);
    for (int c = 0; c < n; c++) begin
      srst[0] = 1'b1;
      cyc();
      if ({ar0, sr0, dn0} !== {4'hF, 4'hF, 1'b0}) begin
        errors++;
        $display("FAIL sync_assert edge=%0d ar=%b sr=%b done=%b expected ar=1111 sr=1111 done=0",
                 edge_n, ar0, sr0, dn0);
      end
      checks++;
    end
    es = edge_n;
    srst[0] = 1'b0;
    done_at = -1;
    for (int c = 0; c < 16; c++) begin
      cyc();
      if ({ar0, sr0, dn0} !== {exp_ar(0), exp_sr(0), exp_dn(0)}) begin
        errors++;
        $display("FAIL sync_release edge=Es+%0d ar=%b sr=%b done=%b expected ar=%b sr=%b done=%b",
                 edge_n - es, ar0, sr0, dn0, exp_ar(0), exp_sr(0), exp_dn(0));
      end
      checks++;
      if (dn0 === 1'b1 && done_at < 0) done_at = edge_n - es;
    end
    if (done_at !== 10) begin
      errors++;
      $display("FAIL sync_done_edge got Es+%0d expected Es+10", done_at);
    end
    checks++;
  endtask

  task automatic test_soft();
    int hi;
    hi = 0;
    for (int c = 0; c < 7; c++) begin
      req0 = (c == 0) ? 4'b0101 : 4'b0000;
      cyc();
      if ({ar0, sr0, dn0} !== {exp_ar(0), exp_sr(0), exp_dn(0)}) begin
        errors++;
        $display("FAIL soft_0101 edge=Eq+%0d ar=%b sr=%b done=%b expected ar=%b sr=%b done=%b",
                 c, ar0, sr0, dn0, exp_ar(0), exp_sr(0), exp_dn(0));
      end
      checks++;
      if (sr0[2] === 1'b1) hi++;
    end
    if (hi !== 4) begin
      errors++;
      $display("FAIL soft_pulse_len ch2 high for %0d cycles expected 4", hi);
    end
    checks++;
    hi = 0;
    for (int c = 0; c < 9; c++) begin
      req0 = (c == 0 || c == 2) ? 4'b0010 : 4'b0000;
      cyc();
      if ({ar0, sr0, dn0} !== {exp_ar(0), exp_sr(0), exp_dn(0)}) begin
        errors++;
        $display("FAIL soft_extend edge=Eq+%0d ar=%b sr=%b done=%b expected ar=%b sr=%b done=%b",
                 c, ar0, sr0, dn0, exp_ar(0), exp_sr(0), exp_dn(0));
      end
      checks++;
      if (sr0[1] === 1'b1) hi++;
    end
    if (hi !== 6) begin
      errors++;
      $display("FAIL soft_extend_len ch1 high for %0d cycles expected 6", hi);
    end
    checks++;
    for (int c = 0; c < 30; c++) begin
      req0 = 4'($urandom) & 4'($urandom);
      cyc();
      if ({ar0, sr0, dn0} !== {exp_ar(0), exp_sr(0), exp_dn(0)}) begin
        errors++;
        $display("FAIL soft_random edge=%0d req=%b ar=%b sr=%b done=%b expected ar=%b sr=%b done=%b",
                 edge_n, req0, ar0, sr0, dn0, exp_ar(0), exp_sr(0), exp_dn(0));
      end
      checks++;
    end
    req0 = '0;
  endtask

  task automatic test_async_mid();
    bit seen;
    int done_at;
    srst[0] = 1'b1;
    cyc();
    srst[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cyc();
      if ({ar0, sr0, dn0} !== {exp_ar(0), exp_sr(0), exp_dn(0)}) begin
        errors++;
        $display("FAIL async_mid_pre edge=%0d ar=%b sr=%b done=%b expected ar=%b sr=%b done=%b",
                 edge_n, ar0, sr0, dn0, exp_ar(0), exp_sr(0), exp_dn(0));
      end
      checks++;
      if (ar0[0] === 1'b0) seen = 1'b1;
    end
    if (!seen) begin
      errors++;
      $display("FAIL async_mid_wait ch0 never released within 20 cycles ar=%b", ar0);
    end
    checks++;
    #2;
    arst[0] = 1'b1;
    m_async_assert(0);
    #1;
    if ({ar0, sr0, dn0} !== {4'hF, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL async_mid_immediate ar=%b sr=%b done=%b expected ar=1111 sr=1111 done=0",
               ar0, sr0, dn0);
    end
    checks++;
    #1;
    arst[0] = 1'b0;
    m_async_release(0);
    base0 = edge_n;
    done_at = -1;
    for (int c = 0; c < 14; c++) begin
      cyc();
      if ({ar0, sr0, dn0} !== {exp_ar(0), exp_sr(0), exp_dn(0)}) begin
        errors++;
        $display("FAIL async_mid_restart edge=E%0d ar=%b sr=%b done=%b expected ar=%b sr=%b done=%b",
                 edge_n - base0, ar0, sr0, dn0, exp_ar(0), exp_sr(0), exp_dn(0));
      end
      checks++;
      if (dn0 === 1'b1 && done_at < 0) done_at = edge_n - base0;
    end
    if (done_at !== 12) begin
      errors++;
      $display("FAIL async_mid_done_edge got E%0d expected E12", done_at);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      srst[0] = ($urandom_range(0, 24) == 0);
      req0    = 4'($urandom) & 4'($urandom);
      cyc();
      if ({ar0, sr0, dn0} !== {exp_ar(0), exp_sr(0), exp_dn(0)}) begin
        errors++;
        $display("FAIL random edge=%0d srst=%b req=%b ar=%b sr=%b done=%b expected ar=%b sr=%b done=%b",
                 edge_n, srst[0], req0, ar0, sr0, dn0, exp_ar(0), exp_sr(0), exp_dn(0));
      end
      checks++;
      if ($urandom_range(0, 59) == 0) begin
        #2;
        arst[0] = 1'b1;
        m_async_assert(0);
        #1;
        if ({ar0, sr0, dn0} !== {4'hF, 4'hF, 1'b0}) begin
          errors++;
          $display("FAIL random_async ar=%b sr=%b done=%b expected ar=1111 sr=1111 done=0", ar0, sr0, dn0);
        end
        checks++;
        #1;
        arst[0] = 1'b0;
        m_async_release(0);
      end
    end
    srst[0] = 1'b0;
    req0    = '0;
  endtask

  task automatic test_small();
    int e;
    #2;
    arst[1] = 1'b0;
    m_async_release(1);
    base1 = edge_n;
    for (int c = 0; c < 7; c++) begin
      req1 = (edge_n + 1 - base1 == 5) ? 1'b1 : 1'b0;
      cyc();
      e = edge_n - base1;
      if ({3'b000, ar1, 3'b000, sr1, dn1} !== {exp_ar(1), exp_sr(1), exp_dn(1)}) begin
        errors++;
        $display("FAIL small edge=E%0d ar=%b sr=%b done=%b expected ar=%b sr=%b done=%b",
                 e, ar1, sr1, dn1, exp_ar(1), exp_sr(1), exp_dn(1));
      end
      checks++;
      if (e == 2 || e == 3) begin
        if ({ar1, dn1} !== ((e == 3) ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL small_release E%0d ar=%b done=%b expected ar=%0d done=%0d",
                   e, ar1, dn1, (e == 3) ? 0 : 1, (e == 3) ? 1 : 0);
        end
        checks++;
      end
      if (e == 5 || e == 6) begin
        if (sr1 !== ((e == 5) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL small_soft E%0d sr=%b expected %0d", e, sr1, (e == 5) ? 1 : 0);
        end
        checks++;
      end
    end
    req1 = '0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        rel_e[i][k]  = INF;
        soft_e[i][k] = 0;
      end
    end
    test_reset();
    test_sequence();
    test_sync_rst();
    test_soft();
    test_async_mid();
    test_random();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
